rename_map_table: RTL and testbench

- N-wide, parametrised register rename map table for the out-of-order core.
- Maps architectural source and destination registers of up to RENAME_WIDTH instructions per cycle to physical registers.
- Tracks a per-architectural-register pending (busy) bit, cleared by WB_PORTS writeback channels.
- Holds NUM_CKPT branch checkpoints for single-cycle misprediction recovery. Sits between decode/free-list and dispatch/ROB.

---
 rtl/rename_map_table.sv | 237 +++++++++++++++++++++++
 tb/tb_rename_map_table.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rename_map_table.sv
// N-wide register rename map table with per-arch-reg busy bits, writeback clears
// and a circular FIFO of branch checkpoints for single-cycle mispredict recovery.
module rename_map_table #(
  parameter int RENAME_WIDTH       = 2,
  parameter int WB_PORTS           = 3,
  parameter int ARCH_REGS          = 32,
  parameter int REG_ADDR_WIDTH     = 5,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int NUM_CKPT           = 4,
  parameter int CKPT_ID_WIDTH      = 2,
  localparam int LANE_WIDTH = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [RENAME_WIDTH-1:0]                    rn_valid_i,
  input  logic [RENAME_WIDTH*REG_ADDR_WIDTH-1:0]     rn_rs1_i,
  input  logic [RENAME_WIDTH*REG_ADDR_WIDTH-1:0]     rn_rs2_i,
  input  logic [RENAME_WIDTH*REG_ADDR_WIDTH-1:0]     rn_rd_i,
  input  logic [RENAME_WIDTH-1:0]                    rn_uses_rd_i,
  input  logic [RENAME_WIDTH*PHY_REG_ADDR_WIDTH-1:0] rn_prd_i,
  output logic [RENAME_WIDTH-1:0]                    rn_valid_o,
  output logic [RENAME_WIDTH*PHY_REG_ADDR_WIDTH-1:0] rn_prs1_o,
  output logic [RENAME_WIDTH*PHY_REG_ADDR_WIDTH-1:0] rn_prs2_o,
  output logic [RENAME_WIDTH*PHY_REG_ADDR_WIDTH-1:0] rn_lprd_o,
  output logic [RENAME_WIDTH-1:0]                    rn_prs1_busy_o,
  output logic [RENAME_WIDTH-1:0]                    rn_prs2_busy_o,
  input  logic [WB_PORTS-1:0]                        wb_valid_i,
  input  logic [WB_PORTS*REG_ADDR_WIDTH-1:0]         wb_rd_i,
  input  logic [WB_PORTS*PHY_REG_ADDR_WIDTH-1:0]     wb_prd_i,
  input  logic                                       ckpt_alloc_i,
  input  logic [LANE_WIDTH-1:0]                      ckpt_lane_i,
  output logic [CKPT_ID_WIDTH-1:0]                   ckpt_id_o,
  output logic                                       ckpt_full_o,
  input  logic                                       ckpt_release_i,
  input  logic                                       restore_i,
  input  logic [CKPT_ID_WIDTH-1:0]                   restore_id_i
);

  localparam int RA = REG_ADDR_WIDTH;
  localparam int PA = PHY_REG_ADDR_WIDTH;
  localparam int CW = CKPT_ID_WIDTH;

  logic [PA-1:0]        map_reg   [ARCH_REGS];
  logic [ARCH_REGS-1:0] busy_reg;
  logic [PA-1:0]        ckpt_map  [NUM_CKPT][ARCH_REGS];
  logic [ARCH_REGS-1:0] ckpt_busy [NUM_CKPT];
  logic [NUM_CKPT-1:0]  ckpt_valid;
  logic [CW-1:0]        head, tail;
  logic [CW:0]          count;

  logic [RA-1:0] rs1 [RENAME_WIDTH];
  logic [RA-1:0] rs2 [RENAME_WIDTH];
  logic [RA-1:0] rd  [RENAME_WIDTH];
  logic [PA-1:0] prd [RENAME_WIDTH];
  logic [RENAME_WIDTH-1:0] we;
  logic [RA-1:0] wb_rd  [WB_PORTS];
  logic [PA-1:0] wb_prd [WB_PORTS];

  logic restore_ok, release_ok, alloc_ok;

  // A restore naming an invalid slot is treated as if restore were not asserted.
  assign restore_ok = restore_i & ckpt_valid[restore_id_i];

  for (genvar gi = 0; gi < RENAME_WIDTH; gi++) begin : g_lane
    assign rs1[gi] = rn_rs1_i[gi*RA +: RA];
    assign rs2[gi] = rn_rs2_i[gi*RA +: RA];
    assign rd[gi]  = rn_rd_i[gi*RA +: RA];
    assign prd[gi] = rn_prd_i[gi*PA +: PA];
    assign we[gi]  = rn_valid_i[gi] & rn_uses_rd_i[gi] & (rd[gi] != '0) & ~restore_ok;
  end

  for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_wb
    assign wb_rd[gi]  = wb_rd_i[gi*RA +: RA];
    assign wb_prd[gi] = wb_prd_i[gi*PA +: PA];
  end

  // Writeback clears only land where the stored tag still matches.
  logic [ARCH_REGS-1:0] wb_clr;
  always_comb begin
    wb_clr = '0;
    for (int k = 0; k < WB_PORTS; k++)
      if (wb_valid_i[k] && wb_rd[k] != '0 && map_reg[wb_rd[k]] == wb_prd[k])
        wb_clr[wb_rd[k]] = 1'b1;
  end

  logic [ARCH_REGS-1:0] ckpt_clr [NUM_CKPT];
  for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_ckpt_clr
    always_comb begin
      ckpt_clr[gi] = '0;
      for (int k = 0; k < WB_PORTS; k++)
        if (wb_valid_i[k] && wb_rd[k] != '0 && ckpt_map[gi][wb_rd[k]] == wb_prd[k])
          ckpt_clr[gi][wb_rd[k]] = 1'b1;
    end
  end

  logic [PA-1:0]           prs1 [RENAME_WIDTH];
  logic [PA-1:0]           prs2 [RENAME_WIDTH];
  logic [PA-1:0]           lprd [RENAME_WIDTH];
  logic [RENAME_WIDTH-1:0] prs1_busy, prs2_busy;

  // Older lanes are scanned oldest-first so the youngest matching producer wins.
  always_comb begin
    prs1_busy = '0;
    prs2_busy = '0;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      prs1[j]      = map_reg[rs1[j]];
      prs2[j]      = map_reg[rs2[j]];
      lprd[j]      = map_reg[rd[j]];
      prs1_busy[j] = busy_reg[rs1[j]] & ~wb_clr[rs1[j]];
      prs2_busy[j] = busy_reg[rs2[j]] & ~wb_clr[rs2[j]];
      for (int i = 0; i < j; i++) begin
        if (we[i] && rd[i] == rs1[j]) begin
          prs1[j]      = prd[i];
          prs1_busy[j] = 1'b1;
        end
        if (we[i] && rd[i] == rs2[j]) begin
          prs2[j]      = prd[i];
          prs2_busy[j] = 1'b1;
        end
        if (we[i] && rd[i] == rd[j])
          lprd[j] = prd[i];
      end
    end
  end

  logic [PA-1:0]        map_next  [ARCH_REGS];
  logic [PA-1:0]        snap_map  [ARCH_REGS];
  logic [ARCH_REGS-1:0] busy_next, snap_busy;

  // The snapshot sees only lanes up to and including the branch lane.
  always_comb begin
    for (int r = 0; r < ARCH_REGS; r++) begin
      map_next[r] = map_reg[r];
      snap_map[r] = map_reg[r];
    end
    busy_next = busy_reg & ~wb_clr;
    snap_busy = busy_reg & ~wb_clr;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      if (we[j]) begin
        map_next[rd[j]]  = prd[j];
        busy_next[rd[j]] = 1'b1;
        if (j <= int'(ckpt_lane_i)) begin
          snap_map[rd[j]]  = prd[j];
          snap_busy[rd[j]] = 1'b1;
        end
      end
    end
    if (restore_ok) begin
      for (int r = 0; r < ARCH_REGS; r++)
        map_next[r] = ckpt_map[restore_id_i][r];
      busy_next = ckpt_busy[restore_id_i] & ~ckpt_clr[restore_id_i];
    end
  end

  assign ckpt_full_o = (count == (CW+1)'(NUM_CKPT));
  assign ckpt_id_o   = tail;
  assign release_ok  = ckpt_release_i & (count != '0) & ~restore_ok;
  assign alloc_ok    = ckpt_alloc_i & (~ckpt_full_o | release_ok) & ~restore_ok;

  logic [CW-1:0]       restore_off;
  logic [NUM_CKPT-1:0] restore_kill;
  assign restore_off = restore_id_i - head;

  // Slots whose age from head is at least the restored slot's age are squashed.
  for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_kill
    logic [CW-1:0] age;
    assign age              = CW'(gi) - head;
    assign restore_kill[gi] = (age >= restore_off);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ARCH_REGS; r++)
        map_reg[r] <= PA'(r);
      busy_reg <= '0;
    end else begin
      for (int r = 0; r < ARCH_REGS; r++)
        map_reg[r] <= map_next[r];
      busy_reg <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ckpt_valid <= '0;
    end else if (restore_ok) begin
      tail       <= restore_id_i;
      count      <= {1'b0, restore_off};
      ckpt_valid <= ckpt_valid & ~restore_kill;
    end else begin
      if (release_ok) begin
        ckpt_valid[head] <= 1'b0;
        head             <= head + 1'b1;
      end
      if (alloc_ok) begin
        ckpt_valid[tail] <= 1'b1;
        tail             <= tail + 1'b1;
      end
      count <= count + {{CW{1'b0}}, alloc_ok} - {{CW{1'b0}}, release_ok};
    end
  end

  // Snapshot payload needs no reset: it is only read through a valid slot.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_CKPT; s++)
      ckpt_busy[s] <= ckpt_busy[s] & ~ckpt_clr[s];
    if (alloc_ok) begin
      ckpt_busy[tail] <= snap_busy;
      for (int r = 0; r < ARCH_REGS; r++)
        ckpt_map[tail][r] <= snap_map[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rn_valid_o     <= '0;
      rn_prs1_o      <= '0;
      rn_prs2_o      <= '0;
      rn_lprd_o      <= '0;
      rn_prs1_busy_o <= '0;
      rn_prs2_busy_o <= '0;
    end else begin
      rn_valid_o     <= restore_ok ? '0 : rn_valid_i;
      rn_prs1_busy_o <= prs1_busy;
      rn_prs2_busy_o <= prs2_busy;
      for (int j = 0; j < RENAME_WIDTH; j++) begin
        rn_prs1_o[j*PA +: PA] <= prs1[j];
        rn_prs2_o[j*PA +: PA] <= prs2[j];
        rn_lprd_o[j*PA +: PA] <= lprd[j];
      end
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: stimulus pushes expected responses into a
// queue and an independent monitor compares them against the registered outputs.
module tb_rename_map_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rn_valid_i, rn_uses_rd_i;
  logic [9:0]  rn_rs1_i, rn_rs2_i, rn_rd_i;
  logic [11:0] rn_prd_i;
  logic [1:0]  rn_valid_o, rn_prs1_busy_o, rn_prs2_busy_o;
  logic [11:0] rn_prs1_o, rn_prs2_o, rn_lprd_o;
  logic [2:0]  wb_valid_i;
  logic [14:0] wb_rd_i;
  logic [17:0] wb_prd_i;
  logic        ckpt_alloc_i, ckpt_release_i, restore_i, ckpt_full_o;
  logic [0:0]  ckpt_lane_i;
  logic [1:0]  ckpt_id_o, restore_id_i;

  rename_map_table dut (
    .clk(clk), .rst(rst),
    .rn_valid_i(rn_valid_i), .rn_rs1_i(rn_rs1_i), .rn_rs2_i(rn_rs2_i), .rn_rd_i(rn_rd_i),
    .rn_uses_rd_i(rn_uses_rd_i), .rn_prd_i(rn_prd_i),
    .rn_valid_o(rn_valid_o), .rn_prs1_o(rn_prs1_o), .rn_prs2_o(rn_prs2_o), .rn_lprd_o(rn_lprd_o),
    .rn_prs1_busy_o(rn_prs1_busy_o), .rn_prs2_busy_o(rn_prs2_busy_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_prd_i(wb_prd_i),
    .ckpt_alloc_i(ckpt_alloc_i), .ckpt_lane_i(ckpt_lane_i), .ckpt_id_o(ckpt_id_o),
    .ckpt_full_o(ckpt_full_o), .ckpt_release_i(ckpt_release_i),
    .restore_i(restore_i), .restore_id_i(restore_id_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    logic [1:0]  vld;
    logic [11:0] p1, p2, lp;
    logic [1:0]  b1, b2;
    bit          tags;
    logic [1:0]  id;
    logic        full;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s.%s got %0h expected %0h", n, f, act, exp);
    else passed++;
  endfunction

  function automatic exp_t mk(input string n, input logic [1:0] v, input int a0, input int a1,
                              input logic [1:0] b1, input int c0, input int c1, input logic [1:0] b2,
                              input int l0, input int l1, input bit tags, input int id, input bit full);
    exp_t e;
    e.due  = 0;
    e.name = n;
    e.vld  = v;
    e.p1   = {6'(a1), 6'(a0)};
    e.p2   = {6'(c1), 6'(c0)};
    e.lp   = {6'(l1), 6'(l0)};
    e.b1   = b1;
    e.b2   = b2;
    e.tags = tags;
    e.id   = 2'(id);
    e.full = full;
    return e;
  endfunction

  // Monitor: pops the entry due this cycle and compares it with the DUT outputs.
  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      $display("txn %-16s cyc=%0d vld=%b prs1=%h lprd=%h busy1=%b id=%0d full=%b",
               mon_e.name, cyc, rn_valid_o, rn_prs1_o, rn_lprd_o, rn_prs1_busy_o, ckpt_id_o, ckpt_full_o);
      chk(mon_e.name, "vld", 32'(rn_valid_o), 32'(mon_e.vld));
      chk(mon_e.name, "ckpt_id", 32'(ckpt_id_o), 32'(mon_e.id));
      chk(mon_e.name, "ckpt_full", 32'(ckpt_full_o), 32'(mon_e.full));
      if (mon_e.tags) begin
        chk(mon_e.name, "prs1", 32'(rn_prs1_o), 32'(mon_e.p1));
        chk(mon_e.name, "prs2", 32'(rn_prs2_o), 32'(mon_e.p2));
        chk(mon_e.name, "lprd", 32'(rn_lprd_o), 32'(mon_e.lp));
        chk(mon_e.name, "busy1", 32'(rn_prs1_busy_o), 32'(mon_e.b1));
        chk(mon_e.name, "busy2", 32'(rn_prs2_busy_o), 32'(mon_e.b2));
      end
    end
  end

  task automatic clear_in();
    rn_valid_i = '0; rn_uses_rd_i = '0; rn_rs1_i = '0; rn_rs2_i = '0; rn_rd_i = '0; rn_prd_i = '0;
    wb_valid_i = '0; wb_rd_i = '0; wb_prd_i = '0;
    ckpt_alloc_i = 1'b0; ckpt_lane_i = '0; ckpt_release_i = 1'b0;
    restore_i = 1'b0; restore_id_i = '0;
  endtask

  task automatic lane(input int j, input int rs1, input int rd, input bit uses, input int prd);
    rn_valid_i[j]         = 1'b1;
    rn_rs1_i[j*5 +: 5]    = 5'(rs1);
    rn_rd_i[j*5 +: 5]     = 5'(rd);
    rn_uses_rd_i[j]       = uses;
    rn_prd_i[j*6 +: 6]    = 6'(prd);
  endtask

  task automatic wb(input int k, input int rd, input int prd);
    wb_valid_i[k]      = 1'b1;
    wb_rd_i[k*5 +: 5]  = 5'(rd);
    wb_prd_i[k*6 +: 6] = 6'(prd);
  endtask

  task automatic step(input exp_t e);
    e.due = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    clear_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_in();
    @(negedge clk);
    lane(0, 5, 0, 0, 0);
    step(mk("reset", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0));
    rst = 1'b0;

    lane(0, 5, 0, 0, 0); lane(1, 7, 0, 0, 0); rn_rs2_i[9:5] = 5'd9;
    step(mk("read_ident", 2'b11, 5, 7, 2'b00, 0, 9, 2'b00, 0, 0, 1, 0, 0));
    lane(0, 0, 3, 1, 40); lane(1, 3, 3, 1, 41);
    step(mk("bypass", 2'b11, 0, 40, 2'b10, 0, 0, 2'b00, 3, 40, 1, 0, 0));
    lane(0, 3, 0, 0, 0); wb(0, 3, 40);
    step(mk("stale_wb", 2'b01, 41, 0, 2'b01, 0, 0, 2'b00, 0, 0, 1, 0, 0));
    lane(0, 3, 0, 0, 0); wb(1, 3, 41);
    step(mk("wb_fwd", 2'b01, 41, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0));
    lane(0, 3, 0, 0, 0);
    step(mk("wb_done", 2'b01, 41, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0));

    ckpt_alloc_i = 1'b1; ckpt_lane_i = 1'b0; lane(0, 0, 4, 1, 50); lane(1, 4, 4, 1, 51);
    step(mk("ckpt_alloc", 2'b11, 0, 50, 2'b10, 0, 0, 2'b00, 4, 50, 1, 1, 0));
    wb(2, 4, 50); lane(0, 4, 0, 0, 0);
    step(mk("snap_wb", 2'b01, 51, 0, 2'b01, 0, 0, 2'b00, 0, 0, 1, 1, 0));
    restore_i = 1'b1; restore_id_i = 2'd0; ckpt_alloc_i = 1'b1; lane(0, 4, 5, 1, 60);
    step(mk("restore", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    lane(0, 4, 0, 0, 0); lane(1, 5, 0, 0, 0);
    step(mk("restored_map", 2'b11, 50, 5, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0));

    for (int i = 1; i <= 4; i++) begin
      ckpt_alloc_i = 1'b1;
      step(mk("alloc", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, i % 4, i == 4));
    end
    ckpt_alloc_i = 1'b1; lane(0, 0, 3, 1, 12);
    step(mk("alloc_full", 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 41, 0, 1, 0, 1));
    ckpt_alloc_i = 1'b1; ckpt_release_i = 1'b1;
    step(mk("rel_alloc", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 1, 1));
    restore_i = 1'b1; restore_id_i = 2'd2;
    step(mk("restore_mid", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2, 0));
    lane(0, 3, 0, 0, 0); lane(1, 4, 0, 0, 0);
    step(mk("restore_mid_map", 2'b11, 41, 50, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2, 0));

    lane(0, 0, 0, 1, 45); lane(1, 0, 0, 0, 0);
    step(mk("rd0", 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2, 0));
    lane(0, 0, 0, 0, 0);
    step(mk("rd0_after", 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2, 0));
    lane(0, 7, 7, 1, 20);
    step(mk("pre_rst", 2'b01, 7, 0, 2'b00, 0, 0, 2'b00, 7, 0, 1, 2, 0));

    #2 rst = 1'b1;
    #1;
    $display("txn %-16s vld=%b prs1=%h lprd=%h id=%0d", "async_rst", rn_valid_o, rn_prs1_o, rn_lprd_o, ckpt_id_o);
    chk("async_rst", "vld", 32'(rn_valid_o), 32'd0);
    chk("async_rst", "prs1", 32'(rn_prs1_o), 32'd0);
    chk("async_rst", "lprd", 32'(rn_lprd_o), 32'd0);
    chk("async_rst", "ckpt_id", 32'(ckpt_id_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lane(0, 7, 0, 0, 0); lane(1, 3, 0, 0, 0);
    step(mk("post_rst", 2'b11, 7, 3, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0));

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", "pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
